// File: rtl/top_mul_rr_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : top_mul_rr_sched_if
// Function : Operand/response bundle shared by the multiplier scheduler.
// Revision : 1.0
// ============================================================================
interface top_mul_rr_sched_if #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 32,
  parameter int B_WIDTH  = 64,
  parameter int P_WIDTH  = 96,
  parameter int ID_WIDTH = 2
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*A_WIDTH-1:0] req_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_b;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [ID_WIDTH-1:0]        rsp_id;
  logic [P_WIDTH-1:0]         rsp_p;
  logic                       busy;
  logic [31:0]                ops_count;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p, busy, ops_count
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p, busy, ops_count
  );
endinterface
`default_nettype wire

// File: rtl/top_mul_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : top_mul_rr_sched
// Function : Round-robin share of one 32x64->96 multiplier, 2-stage pipeline.
// Revision : 1.0
// ============================================================================
module top_mul_rr_sched #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 32,
  parameter int B_WIDTH  = 64,
  parameter int P_WIDTH  = 96,
  parameter int ID_WIDTH = 2
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  top_mul_rr_sched_if.slave  bus
);

  logic                s1_valid_q, s1_valid_d;
  logic [A_WIDTH-1:0]  s1_a_q, s1_a_d;
  logic [B_WIDTH-1:0]  s1_b_q, s1_b_d;
  logic [ID_WIDTH-1:0] s1_id_q, s1_id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [P_WIDTH-1:0]  rsp_p_q, rsp_p_d;
  logic [ID_WIDTH-1:0] rsp_id_q, rsp_id_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [31:0]         ops_count_q, ops_count_d;

  logic                s2_en;
  logic                s1_en;
  logic [NUM_REQ-1:0]  low_mask;
  logic [NUM_REQ-1:0]  upper_req;
  logic [NUM_REQ-1:0]  pick_req;
  logic [NUM_REQ-1:0]  grant_oh;
  logic                grant_found;
  logic                accept;
  logic [ID_WIDTH-1:0] grant_idx;
  logic [A_WIDTH-1:0]  grant_a;
  logic [B_WIDTH-1:0]  grant_b;

  logic [NUM_REQ:0][ID_WIDTH-1:0] idx_chain;
  logic [NUM_REQ:0][A_WIDTH-1:0]  a_chain;
  logic [NUM_REQ:0][B_WIDTH-1:0]  b_chain;

  // Requests at or above the pointer win; otherwise wrap to the lowest index.
  always_comb begin
    s2_en       = !rsp_valid_q || bus.rsp_ready;
    s1_en       = !s1_valid_q || s2_en;
    low_mask    = (NUM_REQ'(1) << rr_ptr_q) - NUM_REQ'(1);
    upper_req   = bus.req_valid & ~low_mask;
    pick_req    = (|upper_req) ? upper_req : bus.req_valid;
    grant_oh    = pick_req & (~pick_req + NUM_REQ'(1));
    grant_found = |bus.req_valid;
    accept      = s1_en && grant_found;
  end

  assign idx_chain[0] = '0;
  assign a_chain[0]   = '0;
  assign b_chain[0]   = '0;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_sel
    assign idx_chain[i+1] = idx_chain[i] | (grant_oh[i] ? ID_WIDTH'(i) : '0);
    assign a_chain[i+1]   = a_chain[i] |
                            ({A_WIDTH{grant_oh[i]}} & bus.req_a[i*A_WIDTH +: A_WIDTH]);
    assign b_chain[i+1]   = b_chain[i] |
                            ({B_WIDTH{grant_oh[i]}} & bus.req_b[i*B_WIDTH +: B_WIDTH]);
  end

  assign grant_idx = idx_chain[NUM_REQ];
  assign grant_a   = a_chain[NUM_REQ];
  assign grant_b   = b_chain[NUM_REQ];

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_id_d     = s1_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_p_d     = rsp_p_q;
    rsp_id_d    = rsp_id_q;
    rr_ptr_d    = rr_ptr_q;
    ops_count_d = ops_count_q;

    if (s2_en) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_p_d  = P_WIDTH'(s1_a_q) * P_WIDTH'(s1_b_q);
        rsp_id_d = s1_id_q;
      end
    end

    if (s1_en) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_a_d  = grant_a;
        s1_b_d  = grant_b;
        s1_id_d = grant_idx;
      end
    end

    if (accept) begin
      rr_ptr_d = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
    end

    if (rsp_valid_q && bus.rsp_ready) begin
      ops_count_d = ops_count_q + 32'd1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_p_q     <= '0;
      rsp_id_q    <= '0;
      rr_ptr_q    <= '0;
      ops_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_p_q     <= rsp_p_d;
      rsp_id_q    <= rsp_id_d;
      rr_ptr_q    <= rr_ptr_d;
      ops_count_q <= ops_count_d;
    end
  end

  assign bus.req_ready = accept ? grant_oh : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_p     = rsp_p_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = s1_valid_q || rsp_valid_q;
  assign bus.ops_count = ops_count_q;

endmodule
`default_nettype wire

// File: tb/tb_top_mul_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_top_mul_rr_sched
// Function : Directed + random checks of the multiplier scheduler vs a queue model.
// Revision : 1.0
// ============================================================================
module tb_top_mul_rr_sched;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int BW = 64;
  localparam int PW = 96;
  localparam int IW = 2;

  logic ap_clk = 1'b0;
  logic ap_rst;
  always #5 ap_clk = ~ap_clk;

  top_mul_rr_sched_if #(.NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .ID_WIDTH(IW)) bus ();

  top_mul_rr_sched #(.NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .ID_WIDTH(IW)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  // Model: ops in acceptance order; an op shows one edge after acceptance,
  // but never before its predecessor has left the response port.
  typedef struct {
    int            id;
    logic [PW-1:0] p;
    int            acc;
  } op_t;

  op_t           q[$];
  int            ptr;
  logic [31:0]   ops_m;
  int            ecount;
  int            last_pop;
  int            vectors;
  int            miscompares;
  logic [N-1:0]  v;
  logic [AW-1:0] ra[N];
  logic [BW-1:0] rb[N];
  logic          rdy;
  logic          rst_r;
  int            mode;
  bit            checking;
  int            ids_seen[$];
  logic [PW-1:0] last_p;
  int            acc_seen;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_ops(input int i);
    case ($urandom_range(0, 5))
      0:       ra[i] = '0;
      1:       ra[i] = '1;
      default: ra[i] = $urandom;
    endcase
    case ($urandom_range(0, 5))
      0:       rb[i] = '0;
      1:       rb[i] = '1;
      default: rb[i] = {$urandom, $urandom};
    endcase
  endtask

  task automatic drive();
    ap_rst        = rst_r;
    bus.req_valid = v;
    bus.rsp_ready = rdy;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*AW +: AW] = ra[i];
      bus.req_b[i*BW +: BW] = rb[i];
    end
  endtask

  // One clock: drive at the falling edge, check mid-low-phase, update model at the rising edge.
  task automatic tick();
    bit           exp_v;
    bit           hs;
    bit           free;
    bit           found;
    int           g;
    int           vis;
    int           idx;
    logic [N-1:0] exp_rdy;
    op_t          o;
    drive();
    #1;
    exp_v = 1'b0;
    if (q.size() > 0) begin
      vis   = (q[0].acc + 1 > last_pop) ? q[0].acc + 1 : last_pop;
      exp_v = (ecount >= vis);
    end
    hs    = exp_v && rdy;
    free  = (q.size() - (hs ? 1 : 0)) < 2;
    found = 1'b0;
    g     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
      if (!found && v[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
    exp_rdy = (found && free) ? (N'(1) << g) : '0;
    if (checking) begin
      chk("req_ready", PW'(bus.req_ready), PW'(exp_rdy));
      chk("rsp_valid", PW'(bus.rsp_valid), PW'(exp_v));
      if (exp_v) begin
        chk("rsp_id", PW'(bus.rsp_id), PW'(q[0].id));
        chk("rsp_p", bus.rsp_p, q[0].p);
      end
      chk("busy", PW'(bus.busy), PW'(q.size() > 0));
      chk("ops_count", PW'(bus.ops_count), PW'(ops_m));
    end
    if (!rst_r && bus.rsp_valid && rdy) begin
      ids_seen.push_back(int'(bus.rsp_id));
      last_p = bus.rsp_p;
    end
    if (!rst_r && (|(v & bus.req_ready))) acc_seen++;
    @(posedge ap_clk);
    ecount++;
    if (rst_r) begin
      q.delete();
      ptr      = 0;
      ops_m    = '0;
      last_pop = 0;
      checking = 1'b1;
    end else begin
      if (hs) begin
        void'(q.pop_front());
        last_pop = ecount;
        ops_m    = ops_m + 32'd1;
      end
      if (found && free) begin
        o.id  = g;
        o.p   = PW'(ra[g]) * PW'(rb[g]);
        o.acc = ecount;
        q.push_back(o);
        ptr = (g + 1) % N;
        if (mode != 1) v[g] = 1'b0;
        if (mode == 3) begin
          new_ops(g);
          v[g] = 1'b1;
        end
      end
      if (mode == 2) begin
        for (int i = 0; i < N; i++) begin
          if (!v[i] && $urandom_range(0, 1) == 1) begin
            new_ops(i);
            v[i] = 1'b1;
          end
        end
      end
    end
    @(negedge ap_clk);
  endtask

  task automatic reset_dut();
    v     = '0;
    rst_r = 1'b1;
    tick();
    rst_r = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ptr         = 0;
    ops_m       = '0;
    ecount      = 0;
    last_pop    = 0;
    checking    = 1'b0;
    mode        = 0;
    v           = '0;
    rdy         = 1'b0;
    rst_r       = 1'b1;
    acc_seen    = 0;
    last_p      = '0;
    for (int i = 0; i < N; i++) begin
      ra[i] = '0;
      rb[i] = '0;
    end
    @(negedge ap_clk);
    tick();
    tick();
    rst_r = 1'b0;

    // Max operands on requester 0
    rdy   = 1'b1;
    ra[0] = '1;
    rb[0] = '1;
    v     = 4'b0001;
    ids_seen.delete();
    repeat (4) tick();
    chk("max_p", last_p, 96'hFFFFFFFE_FFFFFFFF_00000001);
    chk("max_nrsp", PW'(ids_seen.size()), PW'(1));
    chk("max_id", PW'(ids_seen.size() > 0 ? ids_seen[0] : 99), PW'(0));
    chk("max_cnt", PW'(bus.ops_count), PW'(1));

    // Fairness with all requesters held valid
    reset_dut();
    for (int i = 0; i < N; i++) begin
      ra[i] = AW'(i + 1);
      rb[i] = BW'(i + 1) << 32;
    end
    mode = 1;
    v    = '1;
    ids_seen.delete();
    repeat (12) tick();
    mode = 0;
    v    = '0;
    repeat (4) tick();
    chk("fair_nrsp", PW'(ids_seen.size()), PW'(12));
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("fair_id%0d", k), PW'(ids_seen.size() > k ? ids_seen[k] : 99), PW'(k % 4));
    end

    // Pointer wrap: 2 then {0,3} -> 3 then 0
    reset_dut();
    ids_seen.delete();
    new_ops(2);
    v = 4'b0100;
    tick();
    new_ops(0);
    new_ops(3);
    v = 4'b1001;
    repeat (6) tick();
    chk("wrap_nrsp", PW'(ids_seen.size()), PW'(3));
    chk("wrap_id0", PW'(ids_seen.size() > 0 ? ids_seen[0] : 99), PW'(2));
    chk("wrap_id1", PW'(ids_seen.size() > 1 ? ids_seen[1] : 99), PW'(3));
    chk("wrap_id2", PW'(ids_seen.size() > 2 ? ids_seen[2] : 99), PW'(0));

    // Backpressure with continuous requests
    rdy      = 1'b0;
    mode     = 3;
    for (int i = 0; i < N; i++) new_ops(i);
    v        = '1;
    acc_seen = 0;
    repeat (5) tick();
    chk("bp_accepts", PW'(acc_seen), PW'(2));
    rdy = 1'b1;
    repeat (6) tick();
    mode = 0;
    v    = '0;
    repeat (4) tick();

    // Reset with both stages occupied
    rdy = 1'b0;
    new_ops(1);
    v = 4'b0010;
    tick();
    new_ops(2);
    v = 4'b0100;
    tick();
    chk("pre_rst_busy", PW'(bus.busy), PW'(1));
    reset_dut();
    chk("rst_rsp_valid", PW'(bus.rsp_valid), PW'(0));
    chk("rst_busy", PW'(bus.busy), PW'(0));
    chk("rst_ops", PW'(bus.ops_count), PW'(0));
    rdy = 1'b1;
    ids_seen.delete();
    repeat (4) tick();
    chk("rst_no_stale", PW'(ids_seen.size()), PW'(0));
    new_ops(0);
    new_ops(3);
    v = 4'b1001;
    tick();
    chk("rst_ptr_grant0", PW'(ids_seen.size()), PW'(0));
    repeat (5) tick();

    // Zero operand on requester 1
    ra[1] = '0;
    rb[1] = 64'h1234_5678_9ABC_DEF0;
    v     = 4'b0010;
    ids_seen.delete();
    repeat (4) tick();
    chk("zero_p", last_p, PW'(0));
    chk("zero_id", PW'(ids_seen.size() > 0 ? ids_seen[0] : 99), PW'(1));

    // Random traffic with random backpressure
    mode = 2;
    repeat (400) begin
      rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    mode = 0;
    v    = '0;
    rdy  = 1'b1;
    repeat (4) tick();
    chk("final_busy", PW'(bus.busy), PW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
